// File: rtl/bcd2bin_pkg.sv
// Shared constants and types for the 4-digit BCD to binary converter.
// Digits are packed with index 3 = thousands, index 0 = units.
package bcd2bin_pkg;
   localparam int BIN_W   = 14;
   localparam int N_SHIFT = 14;
   localparam int N_DIG   = 4;
   localparam int DIG_W   = 4;
   localparam int CNT_W   = $clog2(N_SHIFT + 1);

   typedef enum logic [1:0] {idle, op, done} state_type;

   typedef logic [N_DIG-1:0][DIG_W-1:0] bcd_vec_t;
endpackage

// File: rtl/bcd2bin_if.sv
// Request/result bundle between a requester (master) and the converter (slave).
interface bcd2bin_if;
   logic                         start;
   logic [3:0]                   bcd3;
   logic [3:0]                   bcd2;
   logic [3:0]                   bcd1;
   logic [3:0]                   bcd0;
   logic                         ready;
   logic                         done_tick;
   logic                         err;
   logic [bcd2bin_pkg::BIN_W-1:0] bin;

   modport master (
      output start, bcd3, bcd2, bcd1, bcd0,
      input  ready, done_tick, err, bin
   );

   modport slave (
      input  start, bcd3, bcd2, bcd1, bcd0,
      output ready, done_tick, err, bin
   );
endinterface

// File: rtl/bcd_sub3.sv
// Reverse double-dabble digit correction: a shifted digit >= 8 gets 3 removed.
module bcd_sub3 (
   input  logic [3:0] i_dig,
   output logic [3:0] o_dig
);
   assign o_dig = (i_dig >= 4'd8) ? (i_dig - 4'd3) : i_dig;
endmodule

// File: rtl/bcd2bin.sv
// 4-digit BCD to 14-bit binary converter, one result bit per clock
// using shift-right / subtract-3, with start/ready/done_tick handshake.
module bcd2bin
   import bcd2bin_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   bcd2bin_if.slave  bus
);
   state_type         r_state, w_state_nxt;
   bcd_vec_t          r_bcd, w_bcd_nxt, w_din, w_shift, w_corr;
   logic [BIN_W-1:0]  r_bin, w_bin_nxt, w_bin_sh;
   logic [CNT_W-1:0]  r_n, w_n_nxt;
   logic              r_err, w_err_nxt;
   logic              w_bad;

   assign w_din = {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};

   always_comb begin
      w_bad = 1'b0;
      for (int k = 0; k < N_DIG; k++)
         if (w_din[k] > 4'd9) w_bad = 1'b1;
   end

   // One right shift of the whole {digits, bin} chain; bcd3 MSB fills with 0.
   assign {w_shift, w_bin_sh} = {1'b0, r_bcd, r_bin[BIN_W-1:1]};

   for (genvar g = 0; g < N_DIG; g++) begin : g_dig
      bcd_sub3 u_sub3 (
         .i_dig (w_shift[g]),
         .o_dig (w_corr[g])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= idle;
         r_bcd   <= '0;
         r_bin   <= '0;
         r_n     <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_bcd   <= w_bcd_nxt;
         r_bin   <= w_bin_nxt;
         r_n     <= w_n_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_bcd_nxt   = r_bcd;
      w_bin_nxt   = r_bin;
      w_n_nxt     = r_n;
      w_err_nxt   = r_err;
      case (r_state)
         idle: begin
            if (bus.start) begin
               w_bin_nxt = '0;
               if (w_bad) begin
                  // Illegal digit: report immediately without shifting.
                  w_err_nxt   = 1'b1;
                  w_state_nxt = done;
               end else begin
                  w_bcd_nxt   = w_din;
                  w_err_nxt   = 1'b0;
                  w_n_nxt     = CNT_W'(N_SHIFT);
                  w_state_nxt = op;
               end
            end
         end
         op: begin
            w_bcd_nxt = w_corr;
            w_bin_nxt = w_bin_sh;
            w_n_nxt   = r_n - 1'b1;
            if (w_n_nxt == '0) w_state_nxt = done;
         end
         done:    w_state_nxt = idle;
         default: w_state_nxt = idle;
      endcase
   end

   assign bus.ready     = (r_state == idle);
   assign bus.done_tick = (r_state == done);
   assign bus.err       = r_err;
   assign bus.bin       = r_bin;
endmodule

// File: tb/tb_bcd2bin.sv
// Directed bench for bcd2bin: decimal-arithmetic model checked every cycle
// plus literal expectations for latency and results of each vector.
module tb_bcd2bin;
   import bcd2bin_pkg::*;

   logic clk = 1'b0;
   logic reset;
   bcd2bin_if bif ();

   bcd2bin dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic bit any_bad(input logic [3:0] a, b, c, d);
      return (a > 9) || (b > 9) || (c > 9) || (d > 9);
   endfunction

   // Model: m_left counts cycles until idle (0 = idle, 1 = done cycle).
   int              m_left;
   logic [BIN_W-1:0] m_bin;
   logic            m_err;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_left <= 0;
         m_bin  <= '0;
         m_err  <= 1'b0;
      end else if (m_left == 0) begin
         if (bif.start) begin
            if (any_bad(bif.bcd3, bif.bcd2, bif.bcd1, bif.bcd0)) begin
               m_left <= 1;
               m_bin  <= '0;
               m_err  <= 1'b1;
            end else begin
               m_left <= 15;
               m_bin  <= BIN_W'(bif.bcd3 * 1000 + bif.bcd2 * 100 + bif.bcd1 * 10 + bif.bcd0);
               m_err  <= 1'b0;
            end
         end
      end else begin
         m_left <= m_left - 1;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("ready", bif.ready, m_left == 0);
         chk("done_tick", bif.done_tick, m_left == 1);
         if (m_left <= 1) begin
            chk("bin", bif.bin, m_bin);
            chk("err", bif.err, m_err);
         end
         if (bif.done_tick && !bif.err)
            chk("digits_zero", dut.r_bcd, 0);
      end
   end

   task automatic set_dig(input logic [3:0] a, b, c, d);
      bif.bcd3 = a; bif.bcd2 = b; bif.bcd1 = c; bif.bcd0 = d;
   endtask

   task automatic run(input logic [3:0] a, b, c, d, input int exp_bin, input bit exp_err,
                      input int exp_lat, input bit chg, input bit poke);
      int lat;
      @(negedge clk);
      set_dig(a, b, c, d);
      bif.start = 1'b1;
      @(negedge clk);
      bif.start = poke;
      if (chg) set_dig(4'd7, 4'd7, 4'd7, 4'd7);
      lat = 1;
      while (!bif.done_tick && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, exp_lat);
      chk("lit_bin", bif.bin, exp_bin);
      chk("lit_err", bif.err, exp_err);
      @(negedge clk);
      bif.start = 1'b0;
      chk("ready_after", bif.ready, 1);
   endtask

   initial begin
      int last, n;
      reset     = 1'b1;
      bif.start = 1'b0;
      set_dig(0, 0, 0, 0);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_bin", bif.bin, 0);
      chk("rst_err", bif.err, 0);
      chk("rst_ready", bif.ready, 1);
      chk("rst_done", bif.done_tick, 0);
      @(negedge clk);
      reset = 1'b0;

      run(9, 9, 9, 9, 9999, 0, 15, 0, 0);
      run(0, 0, 0, 0, 0,    0, 15, 0, 0);
      run(1, 2, 3, 4, 1234, 0, 15, 0, 0);
      run(0, 9, 0, 5, 905,  0, 15, 0, 0);
      run(1, 4'hA, 0, 0, 0, 1, 1,  0, 0);
      run(8, 1, 9, 2, 8192, 0, 15, 0, 0);
      run(0, 0, 0, 4'hF, 0, 1, 1,  0, 0);
      run(4, 3, 2, 1, 4321, 0, 15, 1, 0);
      run(5, 6, 7, 8, 5678, 0, 15, 0, 1);

      // Start held high: one conversion per 16 cycles.
      @(negedge clk);
      set_dig(1, 2, 3, 4);
      bif.start = 1'b1;
      last = -1;
      n = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bif.done_tick) begin
            if (last >= 0) chk("b2b_spacing", i - last, 16);
            chk("b2b_bin", bif.bin, 1234);
            last = i;
            n++;
         end
      end
      chk("b2b_count", n, 3);
      bif.start = 1'b0;
      repeat (20) @(negedge clk);

      // Reset in the middle of a conversion.
      @(negedge clk);
      set_dig(9, 9, 9, 9);
      bif.start = 1'b1;
      @(negedge clk);
      bif.start = 1'b0;
      repeat (6) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_bin", bif.bin, 0);
      chk("abort_err", bif.err, 0);
      chk("abort_ready", bif.ready, 1);
      chk("abort_done", bif.done_tick, 0);
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bif.done_tick) n++;
      end
      chk("abort_no_done", n, 0);
      run(9, 9, 9, 9, 9999, 0, 15, 0, 0);
      run(2, 0, 4, 8, 2048, 0, 15, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bcd2bin.md
Name: bcd2bin

Overview:
- Sequential FSMD converting a 4-digit packed BCD value (0000–9999) into a 14-bit unsigned binary value.
- Uses the reverse double-dabble (shift-right, subtract-3) algorithm: one bit per clock, start/ready/done_tick handshake.
- Companion to the binary-to-BCD converter in the FSMD chapter. Used where keypad/UART decimal entry must become a binary operand.

Parameters:
- None. The format is fixed: 4 BCD digits in, BIN_W=14 bits out, N_SHIFT=14 iterations (constants live in the package).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  conversion request; sampled only while ready=1
- bcd3  input  4  thousands digit
- bcd2  input  4  hundreds digit
- bcd1  input  4  tens digit
- bcd0  input  4  units digit
- ready  output  1  high in idle; converter accepts start
- done_tick  output  1  one-cycle pulse when the result is final
- err  output  1  registered; set if any input digit > 9 at start
- bin  output  14  registered binary result; held until the next accepted start

Behaviour:
Reset (asynchronous, immediate):
- state=idle; all data regs 0.
- Outputs: bin=0, err=0, done_tick=0, ready=1.
- Reset asserted mid-conversion aborts it. No done_tick is produced.

States: idle, op, done. Default branch goes to idle.

idle:
- ready=1.
- If start=1 and all digits ≤ 9:
  - load bcd3_reg..bcd0_reg from the inputs;
  - bin_reg=0, err_reg=0, n_reg=14;
  - go to op.
- If start=1 and any digit > 9:
  - err_reg=1, bin_reg=0;
  - go directly to done. No shifting occurs.
- If start=0, stay in idle and hold all registers.

op (ready=0), each cycle:
- Shift right the 30-bit concatenation {bcd3,bcd2,bcd1,bcd0,bin}:
  - bin_next = {bcd0_reg[0], bin_reg[13:1]}
  - bcdK shifted = {bcd(K+1)_reg[0], bcdK_reg[3:1]}; bcd3 gets 0 at its MSB.
- Correct each shifted digit: if the digit is ≥ 8, subtract 3, else pass it through (4-bit arithmetic, no carry out).
- Register the corrected digits.
- n_next = n_reg − 1. When n_next == 0, go to done.
- Exactly 14 op cycles occur.

done:
- done_tick=1 for exactly one cycle; ready=0.
- Go to idle.
- start during done is ignored; it is not queued.

Timing:
- Start accepted at edge k → op during cycles k+1..k+14 → bin final after edge k+14 → done_tick high in cycle k+15 → ready=1 from cycle k+16.
- Total latency from start to done_tick is 15 cycles. For an err case it is 1 cycle.

Result and hold rules:
- For valid inputs, the digit registers are all 0 at completion. This is an internal self-check; the assertion lives in the bench.
- bin and err hold their values through idle until the next accepted start.
- bin shows partial shift values during op. It is valid only from done_tick onward.
- Input digits may change after the start edge without effect.

Decomposition:
- Package bcd2bin_pkg:
  - typedef enum {idle, op, done} state_type;
  - localparam BIN_W=14, N_SHIFT=14, N_DIG=4.
- Sub-module bcd_sub3 (combinational):
  - in[3:0] → out[3:0] = (in ≥ 8) ? in−3 : in
  - instantiated 4×, once per digit, on the shifted digit value.
- Top module holds the FSM, the n counter, the shift registers and the err register. About 150–200 lines total.

Test Plan:
- Reset then start with 9,9,9,9 → done_tick exactly 15 cycles after the start edge; bin=14'd9999 (0x270F), err=0; ready returns the next cycle.
- Digits 0,0,0,0 → bin=0, err=0, done_tick after 15 cycles. Digits 1,2,3,4 → bin=1234. Digits 0,9,0,5 → bin=905. Back-to-back runs with start held high continuously: each conversion re-arms only in idle, giving one done_tick per 16 cycles.
- Digits 1,0xA,0,0 → done_tick 1 cycle after start, err=1, bin=0. The next valid start (8,1,9,2) → err clears, bin=8192.
- Start pulsed during op and during done → ignored; the result of the first conversion is unaffected; ready stays 0 until idle.
- Assert reset at op cycle 7 of a 9999 conversion → outputs immediately bin=0, err=0, ready=1; no done_tick. A fresh start after release converts correctly.
- Change input digits one cycle after an accepted start of 4,3,2,1 → bin=4321 regardless.
